// File: rtl/deser_pkg.sv
// Shared definitions for the serial receive path: bit-order selectors agreed
// with the serializer, plus the counter sizing helper.
package deser_pkg;

  // Bit-order selectors, common to both ends of the serial link
  localparam int unsigned SERDES_MSB_FIRST = 1;
  localparam int unsigned SERDES_LSB_FIRST = 0;

  // Bit counter width for a word of w bits (at least one bit wide)
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage : deser_pkg

// File: rtl/deser.sv
// deser: serial-to-parallel receiver. Samples sd on each enabled clock,
// assembles WORD_WIDTH-bit words and offers them on a single-entry
// ready/valid port. Sticky flags report dropped words and broken framing.
module deser
  import deser_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned MSB_FIRST  = SERDES_MSB_FIRST
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sd,
  input  logic                  sd_en,
  input  logic                  sync,
  output logic                  valid,
  input  logic                  ready,
  output logic [WORD_WIDTH-1:0] data,
  output logic                  overrun,
  output logic                  frame_err,
  input  logic                  err_clr
);

  localparam int unsigned          CNT_W    = cnt_width(WORD_WIDTH);
  localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(WORD_WIDTH - 1);
  localparam logic [CNT_W-1:0]     ONE_BIT  = CNT_W'(1);

  logic [CNT_W-1:0]      r_bit_cnt;
  logic [CNT_W-1:0]      w_bit_cnt_nxt;
  logic [WORD_WIDTH-1:0] r_shift;
  logic [WORD_WIDTH-1:0] w_shift_base;
  logic [WORD_WIDTH-1:0] w_shift_nxt;
  logic [WORD_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_overrun;
  logic                  r_frame_err;
  logic                  w_complete;
  logic                  w_frame_set;
  logic                  w_accept;
  logic                  w_load;
  logic                  w_drop;

  // Next shift-register contents; a sync bit starts from an empty register
  // so no stale partial-word bits survive into the new word.
  always_comb begin
    w_shift_base = sync ? '0 : r_shift;
    if (MSB_FIRST != SERDES_LSB_FIRST) begin
      w_shift_nxt = (w_shift_base << 1) | WORD_WIDTH'(sd);
    end else begin
      w_shift_nxt = (w_shift_base >> 1) | (WORD_WIDTH'(sd) << (WORD_WIDTH - 1));
    end
  end

  // Bit counter sequencing: restart on sync, wrap at the last bit of a word
  always_comb begin
    w_bit_cnt_nxt = r_bit_cnt;
    w_complete    = 1'b0;
    w_frame_set   = 1'b0;
    if (sd_en) begin
      if (sync) begin
        w_bit_cnt_nxt = ONE_BIT;
        w_frame_set   = (r_bit_cnt != '0);
      end else if (r_bit_cnt == LAST_BIT) begin
        w_bit_cnt_nxt = '0;
        w_complete    = 1'b1;
      end else begin
        w_bit_cnt_nxt = r_bit_cnt + ONE_BIT;
      end
    end
  end

  // Output port decisions: a completed word loads when the slot is empty or
  // being emptied this cycle, otherwise it is dropped.
  always_comb begin
    w_accept = r_valid & ready;
    w_load   = w_complete & (~r_valid | ready);
    w_drop   = w_complete & r_valid & ~ready;
  end

  // Bit counter and shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (sd_en) begin
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // Single-entry output holding register with valid flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_data  <= w_shift_nxt;
      r_valid <= 1'b1;
    end else if (w_accept) begin
      r_valid <= 1'b0;
    end
  end

  // Sticky error flags; a new error wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (err_clr) begin
        r_overrun <= 1'b0;
      end
      if (w_frame_set) begin
        r_frame_err <= 1'b1;
      end else if (err_clr) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  assign valid     = r_valid;
  assign data      = r_data;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule : deser

// File: tb/tb_deser.sv
// Self-checking bench for deser: three instances (8-bit MSB-first, 8-bit
// LSB-first, 5-bit MSB-first) share one stimulus stream and are compared
// against a bit-list reference model plus directed expectations.
module tb_deser;

  logic clk;
  logic rst, sd, sd_en, sync, ready, err_clr;

  logic       valid_a, overrun_a, ferr_a;
  logic [7:0] data_a;
  logic       valid_b, overrun_b, ferr_b;
  logic [7:0] data_b;
  logic       valid_c, overrun_c, ferr_c;
  logic [4:0] data_c;

  int vectors;
  int miscompares;

  deser #(.WORD_WIDTH(8), .MSB_FIRST(1)) u_msb8 (
    .clk(clk), .rst(rst), .sd(sd), .sd_en(sd_en), .sync(sync),
    .valid(valid_a), .ready(ready), .data(data_a),
    .overrun(overrun_a), .frame_err(ferr_a), .err_clr(err_clr)
  );

  deser #(.WORD_WIDTH(8), .MSB_FIRST(0)) u_lsb8 (
    .clk(clk), .rst(rst), .sd(sd), .sd_en(sd_en), .sync(sync),
    .valid(valid_b), .ready(ready), .data(data_b),
    .overrun(overrun_b), .frame_err(ferr_b), .err_clr(err_clr)
  );

  deser #(.WORD_WIDTH(5), .MSB_FIRST(1)) u_msb5 (
    .clk(clk), .rst(rst), .sd(sd), .sd_en(sd_en), .sync(sync),
    .valid(valid_c), .ready(ready), .data(data_c),
    .overrun(overrun_c), .frame_err(ferr_c), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: received bits are kept in arrival order and turned
  // into a word arithmetically once a full word has arrived.
  bit         m_valid [3];
  logic [7:0] m_data  [3];
  bit         m_ovr   [3];
  bit         m_ferr  [3];
  int         m_n     [3];
  bit         m_part  [3][8];

  task automatic model_edge(input int k, input int w, input bit msb);
    logic [7:0] word;
    bit done, set_o, set_f, accepted;
    if (rst) begin
      m_n[k] = 0; m_valid[k] = 0; m_data[k] = '0; m_ovr[k] = 0; m_ferr[k] = 0;
      return;
    end
    done = 0; set_o = 0; set_f = 0; word = '0;
    accepted = m_valid[k] && ready;
    if (sd_en) begin
      if (sync) begin
        if (m_n[k] != 0) set_f = 1;
        m_n[k] = 0;
      end
      m_part[k][m_n[k]] = sd;
      m_n[k]++;
      if (m_n[k] == w) begin
        for (int i = 0; i < w; i++) begin
          if (msb) word = word + (8'(m_part[k][i]) << (w - 1 - i));
          else     word = word + (8'(m_part[k][i]) << i);
        end
        m_n[k] = 0;
        done   = 1;
      end
    end
    if (done) begin
      if (m_valid[k] && !ready) set_o = 1;
      else begin m_data[k] = word; m_valid[k] = 1; end
    end else if (accepted) begin
      m_valid[k] = 0;
    end
    if (set_o) m_ovr[k] = 1; else if (err_clr) m_ovr[k] = 0;
    if (set_f) m_ferr[k] = 1; else if (err_clr) m_ferr[k] = 0;
  endtask

  always @(posedge clk) begin
    model_edge(0, 8, 1);
    model_edge(1, 8, 0);
    model_edge(2, 5, 1);
  end

  // ---------------- stimulus helpers (drive only) ----------------
  task automatic idle(input int n);
    sd_en = 1'b0; sync = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic s);
    sd = b; sd_en = 1'b1; sync = s;
    @(negedge clk);
    sd_en = 1'b0; sync = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] v, input int w, input bit msb, input bit with_sync);
    for (int i = 0; i < w; i++) send_bit(msb ? v[w-1-i] : v[i], with_sync && (i == 0));
  endtask

  task automatic do_reset();
    rst = 1'b1; sd_en = 1'b0; sync = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [10:0] got [3];
    rst = 1'b1; sd = 1'b1; sd_en = 1'b1; sync = 1'b0; ready = 1'b0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    got[0] = {valid_a, data_a, overrun_a, ferr_a};
    got[1] = {valid_b, data_b, overrun_b, ferr_b};
    got[2] = {valid_c, 3'b000, data_c, overrun_c, ferr_c};
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (got[k] !== 11'd0) begin
        miscompares++;
        $display("FAIL reset inst%0d got %h want 000", k, got[k]);
      end
    end
    rst = 1'b0; sd_en = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] v;
    do_reset();
    ready = 1'b1;
    v = 8'hA5;
    for (int i = 0; i < 7; i++) send_bit(v[7-i], i == 0);
    vectors++;
    if (valid_a !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid got %b want 0", valid_a); end
    send_bit(v[0], 1'b0);
    vectors++;
    if (valid_a !== 1'b1) begin miscompares++; $display("FAIL basic_valid got %b want 1", valid_a); end
    vectors++;
    if (data_a !== 8'hA5) begin miscompares++; $display("FAIL basic_data got %h want a5", data_a); end
    vectors++;
    if ({overrun_a, ferr_a} !== 2'b00) begin miscompares++; $display("FAIL basic_flags got %b want 00", {overrun_a, ferr_a}); end
    idle(1);
    vectors++;
    if (valid_a !== 1'b0) begin miscompares++; $display("FAIL basic_accept got %b want 0", valid_a); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    do_reset();
    ready = 1'b1;
    send_word(8'h3C, 8, 1, 1);
    vectors++;
    if ({valid_a, data_a} !== {1'b1, 8'h3C}) begin miscompares++; $display("FAIL b2b_first got %b/%h want 1/3c", valid_a, data_a); end
    v = 8'hC3;
    send_bit(v[7], 1'b0);
    vectors++;
    if (valid_a !== 1'b0) begin miscompares++; $display("FAIL b2b_gap_valid got %b want 0", valid_a); end
    for (int i = 1; i < 8; i++) send_bit(v[7-i], 1'b0);
    vectors++;
    if ({valid_a, data_a, overrun_a} !== {1'b1, 8'hC3, 1'b0}) begin
      miscompares++; $display("FAIL b2b_second got %b/%h/%b want 1/c3/0", valid_a, data_a, overrun_a);
    end
    send_word(8'hA5, 8, 0, 1);
    vectors++;
    if ({valid_b, data_b} !== {1'b1, 8'hA5}) begin miscompares++; $display("FAIL lsb_a5 got %b/%h want 1/a5", valid_b, data_b); end
    send_word(8'h12, 8, 0, 0);
    vectors++;
    if (data_b !== 8'h12) begin miscompares++; $display("FAIL lsb_order got %h want 12", data_b); end
    vectors++;
    if (data_a !== 8'h48) begin miscompares++; $display("FAIL msb_of_lsb_stream got %h want 48", data_a); end
  endtask

  task automatic test_gaps();
    logic [7:0] v;
    do_reset();
    ready = 1'b1;
    v = 8'hF0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        vectors++;
        if (valid_a !== 1'b0) begin miscompares++; $display("FAIL gaps_early got %b want 0", valid_a); end
      end
      send_bit(v[7-i], i == 0);
      if (i < 7) idle(1);
    end
    vectors++;
    if ({valid_a, data_a} !== {1'b1, 8'hF0}) begin miscompares++; $display("FAIL gaps_word got %b/%h want 1/f0", valid_a, data_a); end
  endtask

  task automatic test_overrun();
    do_reset();
    ready = 1'b0;
    send_word(8'h11, 8, 1, 1);
    vectors++;
    if ({valid_a, data_a, overrun_a} !== {1'b1, 8'h11, 1'b0}) begin
      miscompares++; $display("FAIL ovr_first got %b/%h/%b want 1/11/0", valid_a, data_a, overrun_a);
    end
    send_word(8'h22, 8, 1, 0);
    vectors++;
    if ({valid_a, data_a, overrun_a} !== {1'b1, 8'h11, 1'b1}) begin
      miscompares++; $display("FAIL ovr_hold got %b/%h/%b want 1/11/1", valid_a, data_a, overrun_a);
    end
    ready = 1'b1;
    idle(1);
    vectors++;
    if ({valid_a, overrun_a} !== 2'b01) begin miscompares++; $display("FAIL ovr_accept got %b want 01", {valid_a, overrun_a}); end
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    vectors++;
    if (overrun_a !== 1'b0) begin miscompares++; $display("FAIL ovr_clear got %b want 0", overrun_a); end
  endtask

  task automatic test_frame();
    do_reset();
    ready = 1'b1;
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    send_word(8'h5A, 8, 1, 1);
    vectors++;
    if ({valid_a, data_a, ferr_a} !== {1'b1, 8'h5A, 1'b1}) begin
      miscompares++; $display("FAIL frame_err got %b/%h/%b want 1/5a/1", valid_a, data_a, ferr_a);
    end
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    vectors++;
    if ({valid_a, data_a, overrun_a, ferr_a} !== 11'd0) begin
      miscompares++; $display("FAIL midword_reset got %h want 000", {valid_a, data_a, overrun_a, ferr_a});
    end
    send_word(8'h96, 8, 1, 1);
    vectors++;
    if ({valid_a, data_a, ferr_a} !== {1'b1, 8'h96, 1'b0}) begin
      miscompares++; $display("FAIL after_reset got %b/%h/%b want 1/96/0", valid_a, data_a, ferr_a);
    end
  endtask

  task automatic test_width5();
    do_reset();
    ready = 1'b1;
    send_word(8'h19, 5, 1, 1);
    vectors++;
    if ({valid_c, data_c} !== {1'b1, 5'b11001}) begin miscompares++; $display("FAIL w5_word got %b/%b want 1/11001", valid_c, data_c); end
    send_word(8'h16, 5, 1, 1);
    vectors++;
    if (data_c !== 5'b10110) begin miscompares++; $display("FAIL w5_stream1 got %b want 10110", data_c); end
    send_word(8'h0B, 5, 1, 0);
    vectors++;
    if ({valid_c, data_c, ferr_c} !== {1'b1, 5'b01011, 1'b0}) begin
      miscompares++; $display("FAIL w5_stream2 got %b/%b/%b want 1/01011/0", valid_c, data_c, ferr_c);
    end
  endtask

  task automatic test_random();
    logic [10:0] got, exp;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 199) == 0);
      sd      = 1'($urandom);
      sd_en   = ($urandom_range(0, 9) < 7);
      sync    = ($urandom_range(0, 19) == 0);
      ready   = ($urandom_range(0, 9) < 7);
      err_clr = ($urandom_range(0, 29) == 0);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        case (k)
          0:       got = {valid_a, data_a, overrun_a, ferr_a};
          1:       got = {valid_b, data_b, overrun_b, ferr_b};
          default: got = {valid_c, 3'b000, data_c, overrun_c, ferr_c};
        endcase
        exp = {m_valid[k], m_data[k], m_ovr[k], m_ferr[k]};
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL random inst%0d cycle %0d got %h want %h", k, n, got, exp);
        end
      end
    end
    rst = 1'b0; sd_en = 1'b0; sync = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; sd = 1'b0; sd_en = 1'b0; sync = 1'b0; ready = 1'b0; err_clr = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_gaps();
    test_overrun();
    test_frame();
    test_width5();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_deser
